// File: rtl/dsp_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pkg
//   Shared constants for the DSP48A1 MAC sequencer.
//   - OPMODE encodings driven onto the slice (X and Z multiplexer selects only;
//     upper nibble is always zero: add, no carry-in, no pre-adder).
//   - Sequencer state encoding.
// -----------------------------------------------------------------------------
package dsp_pkg;

    // OPMODE[1:0] selects X, OPMODE[3:2] selects Z.
    localparam logic [7:0] OPM_IDLE  = 8'h00;  // X=0, Z=0 (only seen while CEP is low)
    localparam logic [7:0] OPM_FIRST = 8'h01;  // X=M, Z=0 : start a fresh sum
    localparam logic [7:0] OPM_ACC   = 8'h09;  // X=M, Z=P : accumulate onto P

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/dsp_ctl_delay.sv
// -----------------------------------------------------------------------------
// dsp_ctl_delay
//   Fixed-depth shift register used to align control (issue strobe and OPMODE
//   tag) with the slice's internal operand pipeline.
// Ports:
//   clk_i   in   1      rising-edge clock
//   clr_ni  in   1      synchronous active-low clear of every stage
//   d_i     in   WIDTH  value entering the line
//   q_o     out  WIDTH  value leaving the line, DEPTH cycles later
// -----------------------------------------------------------------------------
module dsp_ctl_delay #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             clr_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!clr_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// -----------------------------------------------------------------------------
// dsp_mac_sequencer
//   Drives one DSP48A1-style slice (A1REG=1, B1REG=1, MREG=0, PREG=1,
//   OPMODEREG=0, CARRYINREG=0) to compute sum(A[i]*B[i]) over a burst and
//   returns the 48-bit result on a valid/ready output.
// Parameters:
//   LEN       operands per burst (1..65535); in_last ends a burst early
//   PIPE_LAT  rising edges from operand issue to P holding its sum (2..8)
// Ports:
//   CLK, RSTN               clock, synchronous active-low reset
//   in_valid/in_ready       operand handshake; in_a, in_b operands; in_last
//   dsp_a, dsp_b            operands to the slice (pass-through)
//   dsp_ceab                slice CEA/CEB, equal to the input handshake
//   dsp_cep, dsp_opmode     slice CEP and OPMODE, delayed issue strobe/tag
//   dsp_p, dsp_carryout     slice P and CARRYOUT
//   out_valid/out_ready     result handshake; out_data, out_ovf result
//   busy                    high whenever not IDLE
// -----------------------------------------------------------------------------
module dsp_mac_sequencer
    import dsp_pkg::*;
#(
    parameter int LEN      = 8,
    parameter int PIPE_LAT = 2
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] in_a,
    input  logic [17:0] in_b,
    input  logic        in_last,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic        dsp_ceab,
    output logic        dsp_cep,
    output logic [7:0]  dsp_opmode,
    input  logic [47:0] dsp_p,
    input  logic        dsp_carryout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] out_data,
    output logic        out_ovf,
    output logic        busy
);

    localparam logic [15:0] LEN_W      = 16'(LEN);
    localparam logic [3:0]  DRAIN_LAST = 4'(PIPE_LAT - 1);
    localparam int          DLY_DEPTH  = PIPE_LAT - 1;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  dcnt_q, dcnt_d;
    logic        out_valid_q, out_valid_d;
    logic [47:0] out_data_q, out_data_d;
    logic        ovf_q, ovf_d;

    logic        issue;
    logic [7:0]  tag;
    logic [8:0]  dly_out;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dcnt_d      = dcnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ovf_d       = ovf_q;
        in_ready    = 1'b0;
        issue       = 1'b0;
        tag         = OPM_IDLE;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    issue  = 1'b1;
                    tag    = OPM_FIRST;
                    ovf_d  = 1'b0;
                    cnt_d  = 16'd1;
                    dcnt_d = '0;
                    if (LEN_W == 16'd1 || in_last) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    issue = 1'b1;
                    tag   = OPM_ACC;
                    cnt_d = cnt_q + 16'd1;
                    // Count limit and in_last on the same operand collapse into one end.
                    if (cnt_d == LEN_W || in_last) begin
                        state_d = DRAIN;
                        dcnt_d  = '0;
                    end
                end
            end
            DRAIN: begin
                // Capture on the PIPE_LAT-th edge after the last issuing edge.
                if (dcnt_q == DRAIN_LAST) begin
                    out_data_d  = dsp_p;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    dcnt_d = dcnt_q + 4'd1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Evaluated after the burst-start clear so a carry in the same cycle still sticks.
        if (dsp_cep && dsp_carryout) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dcnt_q      <= dcnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
        end
    end

    // {tag, issue} travel together so OPMODE lines up with CEP at the P register.
    dsp_ctl_delay #(
        .WIDTH (9),
        .DEPTH (DLY_DEPTH)
    ) u_ctl_delay (
        .clk_i  (CLK),
        .clr_ni (RSTN),
        .d_i    ({tag, issue}),
        .q_o    (dly_out)
    );

    assign dsp_a      = in_a;
    assign dsp_b      = in_b;
    assign dsp_ceab   = issue;
    assign dsp_cep    = dly_out[0];
    assign dsp_opmode = dly_out[0] ? dly_out[8:1] : OPM_IDLE;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_ovf    = ovf_q;
    assign busy       = (state_q != IDLE);

endmodule
